// File: rtl/insert_sched.sv
// Window-granular round-robin scheduler sharing one bit-insertion unit among NREQ requesters.
// Optional build macro INSERT_SCHED_EARLY_REL_EN: end a burst at a window boundary once the holder drops iReq.
module insert_sched #(
    parameter int unsigned BITWIDTH  = 8,
    parameter int unsigned FBITWIDTH = 4,
    parameter int unsigned NREQ      = 4,
    parameter int unsigned WINLOG2   = 3,
    parameter int unsigned NWIN      = 2
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic [NREQ-1:0]           iReq,
    input  logic [NREQ*FBITWIDTH-1:0] iProb,
    input  logic [NREQ-1:0]           iBit,
    input  logic                      iIns,
    output logic                      oEn,
    output logic                      oClr,
    output logic [FBITWIDTH-1:0]      oProb,
    output logic [BITWIDTH-1:0]       oWindow,
    output logic [BITWIDTH-1:0]       oWINLOG2,
    output logic                      oA,
    output logic [NREQ-1:0]           oGnt,
    output logic [NREQ-1:0]           oDone,
    output logic                      oBit,
    output logic [NREQ-1:0]           oBitValid,
    output logic                      oBusy
);

    localparam int unsigned IW   = $clog2(NREQ);
    localparam int unsigned BW   = WINLOG2 + $clog2(NWIN + 1);
    localparam int unsigned NRUN = NWIN << WINLOG2;
    localparam logic [BW-1:0]       LAST   = BW'(NRUN - 1);
    localparam logic [BITWIDTH-1:0] WINDOW = BITWIDTH'(1 << WINLOG2);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_t;

    state_t                 state;
    logic [IW-1:0]          idx;
    logic [IW-1:0]          ptr;
    logic [BW-1:0]          bcnt;
    logic                   en_d;

    logic [FBITWIDTH-1:0]   prob_arr [NREQ];
    logic                   sel_vld;
    logic [IW-1:0]          sel_idx;
    logic [FBITWIDTH-1:0]   sel_prob;
    logic                   run_last;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            prob_arr[i] = iProb[i*FBITWIDTH +: FBITWIDTH];
        end
    end

    // Round-robin search starts just above the last granted index and wraps.
    always_comb begin
        int unsigned   c;
        logic [IW-1:0] c_idx;
        c        = 0;
        c_idx    = '0;
        sel_vld  = 1'b0;
        sel_idx  = '0;
        sel_prob = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            c     = ({{(32-IW){1'b0}}, ptr} + k) % NREQ;
            c_idx = IW'(c);
            if (!sel_vld && iReq[c_idx]) begin
                sel_vld  = 1'b1;
                sel_idx  = c_idx;
                sel_prob = prob_arr[c_idx];
            end
        end
    end

    always_comb begin
        run_last = (bcnt == LAST);
`ifdef INSERT_SCHED_EARLY_REL_EN
        if (!iReq[idx] && (&bcnt[WINLOG2-1:0])) begin
            run_last = 1'b1;
        end
`endif
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= IDLE;
            idx   <= '0;
            ptr   <= IW'(NREQ - 1);
            bcnt  <= '0;
            en_d  <= 1'b0;
            oEn   <= 1'b0;
            oClr  <= 1'b0;
            oGnt  <= '0;
            oDone <= '0;
            oProb <= '0;
        end else begin
            en_d  <= oEn;
            oDone <= '0;
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        idx   <= sel_idx;
                        oProb <= sel_prob;
                        oGnt  <= NREQ'(1) << sel_idx;
                        oClr  <= 1'b1;
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    oClr  <= 1'b0;
                    oEn   <= 1'b1;
                    bcnt  <= '0;
                    state <= RUN;
                end
                RUN: begin
                    bcnt <= bcnt + 1'b1;
                    if (run_last) begin
                        oEn   <= 1'b0;
                        oDone <= oGnt;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Grant is held through DRAIN so the last registered unit bit stays qualified.
                    ptr   <= idx;
                    oGnt  <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign oA        = oEn & iBit[idx];
    assign oBitValid = oGnt & {NREQ{en_d}};
    assign oBit      = iIns;
    assign oBusy     = (state != IDLE);
    assign oWindow   = WINDOW;
    assign oWINLOG2  = BITWIDTH'(WINLOG2);

endmodule

// File: doc/insert_sched.md
# insert_sched

Window-granular round-robin scheduler that shares one `rng_insert`-style bit-insertion unit among `NREQ` stochastic-stream requesters. It grants the unit to one requester for a fixed burst of `NWIN` windows. During the burst it clears and enables the unit, muxes the granted requester's input bit and latched probability into it, and routes the unit's registered output back with a one-hot valid. It sits between the requester streams and a single insertion datapath.

## Interface
- `BITWIDTH`, 8, width of the unit's window/count ports.
- `FBITWIDTH`, 4, probability width (fixed point, 0.5 = `0100`).
- `NREQ`, 4, number of requesters (≥2).
- `WINLOG2`, 3, log2 of the window length (window = `1<<WINLOG2`).
- `NWIN`, 2, windows per grant (≥1).

- `iClk`  in  1  clock.
- `iRst`  in  1  reset; asynchronous, active-high.
- `iReq`  in  NREQ  per-requester request level.
- `iProb`  in  NREQ*FBITWIDTH  packed probabilities; requester i uses bits `[i*FBITWIDTH +: FBITWIDTH]`.
- `iBit`  in  NREQ  per-requester stream bit.
- `iIns`  in  1  insertion unit output (`out`).
- `oEn`, `oClr`  out  1  drive unit `iEn` / `iClr`.
- `oProb`  out  FBITWIDTH  drives unit `iProb`.
- `oWindow`  out  BITWIDTH  constant `1<<WINLOG2`.
- `oWINLOG2`  out  BITWIDTH  constant `WINLOG2`.
- `oA`  out  1  drives unit `iA`.
- `oGnt`  out  NREQ  one-hot grant.
- `oDone`  out  NREQ  one-hot, 1-cycle end-of-burst pulse.
- `oBit`  out  1  returned bit (`iIns` passthrough).
- `oBitValid`  out  NREQ  one-hot qualifier for `oBit`.
- `oBusy`  out  1  FSM not in IDLE.

## Operation
- FSM states are IDLE, CLEAR, RUN and DRAIN, held in a 2-bit state register.
- **IDLE**
  - `oEn`, `oClr`, `oGnt` and `oA` are 0.
  - If `iReq` is nonzero, select the first set bit searching upward (wrapping) from `ptr+1`, where `ptr` is the last granted index.
  - Latch the selected index `idx` and `iProb[idx]`, then go to CLEAR.
- **CLEAR** (1 cycle)
  - `oClr`=1, `oEn`=0, `oGnt[idx]`=1, `oProb` = latched value.
  - Reset the burst counter `bcnt` to 0. Go to RUN.
- **RUN** (exactly `NWIN<<WINLOG2` cycles)
  - `oEn`=1, `oA`=`iBit[idx]` (combinational mux), `bcnt` increments.
  - Leave for DRAIN on the cycle `bcnt == (NWIN<<WINLOG2)-1`.
- **DRAIN** (1 cycle)
  - `oEn`=0, `oDone[idx]`=1, `ptr`←`idx`. Go to IDLE.
- `bcnt` width is `WINLOG2 + $clog2(NWIN+1)`. The window index is `bcnt>>WINLOG2`; the in-window position is `bcnt[WINLOG2-1:0]`.
- `oBitValid` is `oGnt & {NREQ{en_d}}`, where `en_d` is `oEn` delayed one cycle. This matches the unit's one-cycle registered output.
- `oProb` and `idx` are latched only in IDLE. Changes to `iProb` or `iReq` during a burst are ignored; a dropped `iReq` still completes the burst.
- `oProb` holds its last value in IDLE. `oWindow` and `oWINLOG2` are constants.

## Timing
- Reset value of every output is 0, except the constants `oWindow` and `oWINLOG2`.
  - Reset also sets state=IDLE, `ptr`=NREQ-1 (so requester 0 wins first), `bcnt`=0 and `en_d`=0.
- Reset asserted mid-burst: all outputs drop asynchronously. No `oDone` is issued. After release, arbitration restarts from requester 0.
- Let t be the IDLE cycle that samples `iReq`. Then:
  - t+1: CLEAR.
  - t+2 … t+1+N: RUN, where N = `NWIN<<WINLOG2`.
  - t+3 … t+2+N: `oBitValid`.
  - t+2+N: DRAIN with `oDone`.
  - t+3+N: IDLE. The earliest next CLEAR is t+4+N.
- Per-burst overhead is 3 idle-unit cycles (CLEAR, DRAIN, IDLE).
- A request arriving during a burst waits. Simultaneous requests are resolved purely by round-robin order.

## Configuration
- Macro: `INSERT_SCHED_EARLY_REL_EN`.
- Defined:
  - In RUN, if `iReq[idx]`=0 at the last in-window position (`bcnt[WINLOG2-1:0]` all ones), go to DRAIN after that cycle instead of continuing.
  - `oDone` and `oBitValid` timing follow the same DRAIN rules. Bursts are always whole windows, minimum 1.
- Undefined: every burst lasts exactly `NWIN` windows regardless of `iReq`.

## Test plan
- Reset, then hold `iReq`=0 for 10 cycles: all outputs 0, `oBusy`=0, `oWindow`=8, `oWINLOG2`=3.
- `iReq`=4'b0010, `iProb[1]`=4'b0110: `oGnt`=0010, one `oClr` cycle, then `oEn`=1 for exactly 16 cycles with `oProb`=0110. `oBitValid`=0010 for 16 cycles lagging `oEn` by 1. `oDone`=0010 on the cycle after the last `oEn`.
- `iReq`=4'b1111 held constant: grants are issued in order 0,1,2,3,0, each 19 cycles apart.
- Change `iProb[0]` and drop `iReq[0]` mid-burst: `oProb` unchanged and the burst still lasts 16 RUN cycles (macro undefined).
- Assert `iRst` at RUN cycle 5: outputs 0 immediately with no `oDone`. After release with `iReq`=4'b1001, requester 0 is granted.
- With `INSERT_SCHED_EARLY_REL_EN` defined, drop `iReq[2]` in window 0: RUN lasts 8 cycles, then `oDone`=0100.
